snitch_lsu_mem_adapter: RTL and testbench
=========================================

# snitch_lsu_mem_adapter

Sits directly downstream of the Snitch LSU's ID-tagged memory channel and drives a TCDM-style memory port (req/gnt, in-order rvalid without backpressure). It captures the LSU's transaction ID for every granted request and replays it on the matching response. It buffers responses so that an LSU stall (data_pready low) never loses memory data. Credit accounting limits outstanding-plus-buffered transactions to NumOutstanding.

## Interface
- NumOutstanding, 4: max transactions granted but not yet accepted by the LSU; also the depth of the ID and response FIFOs; ≥1.
- IdWidth, idx_width(NumOutstanding): width of data_qid_i / data_pid_o; derived, not overridden.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_qaddr_i  in  32  word-aligned address from LSU.
- data_qwrite_i  in  1  write request.
- data_qamo_i  in  4  AMO opcode.
- data_qdata_i  in  32  write data, pre-aligned.
- data_qstrb_i  in  4  byte enables.
- data_qid_i  in  IdWidth  LSU transaction ID.
- data_qvalid_i  in  1  request valid.
- data_qready_o  out  1  request accepted.
- data_pdata_o  out  32  response data.
- data_perror_o  out  1  response error.
- data_pid_o  out  IdWidth  ID of the request this response belongs to.
- data_pvalid_o  out  1  response valid.
- data_pready_i  in  1  LSU accepts response.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant; request transfers on req&gnt.
- mem_addr_o, mem_we_o, mem_amo_o, mem_wdata_o, mem_be_o  out  32/1/4/32/4  pass-through of the q fields.
- mem_rvalid_i  in  1  one pulse per granted request (reads and writes), in grant order, ≥1 cycle after grant, no backpressure.
- mem_rdata_i  in  32  response data.
- mem_err_i  in  1  response error.

## Operation
- Credit counter cnt (0..NumOutstanding): +1 on grant (mem_req_o & mem_gnt_i), −1 on LSU response handshake (data_pvalid_o & data_pready_i); both in the same cycle leaves it unchanged.
- credit_ok = cnt < NumOutstanding. mem_req_o = data_qvalid_i & credit_ok. data_qready_o = mem_gnt_i & credit_ok. The q fields drive the mem_* outputs combinationally.
- While a request waits for grant, cnt can only decrease, so mem_req_o never deasserts once raised while data_qvalid_i stays high.
- ID FIFO (depth NumOutstanding): push data_qid_i on grant. Pop on the LSU response handshake. data_pid_o = ID FIFO head.
- Response FIFO (depth NumOutstanding, {rdata, err}): push on mem_rvalid_i. Pop on the LSU response handshake. data_pvalid_o = response FIFO not empty; data_pdata_o and data_perror_o come from its head.
- Credits guarantee both FIFOs never overflow. mem_rvalid_i with no granted-but-unanswered transaction is a protocol error: simulation assertion fires; RTL behaviour is undefined.
- Writes get responses like loads. The LSU decides whether to forward them.

## Timing
- Reset: data_qready_o=0, mem_req_o=0, data_pvalid_o=0, data_pdata_o=0, data_perror_o=0, data_pid_o=0. cnt=0, both FIFOs empty.
- Request path latency is zero: combinational from data_qvalid_i and mem_gnt_i.
- Response path: mem_rvalid_i in cycle t gives data_pvalid_o in cycle t+1 (FIFO registered), unless the bypass below is compiled in.
- Full condition: cnt==NumOutstanding gives mem_req_o=0 and data_qready_o=0. A response handshake in that cycle restores credit from the next cycle; there is no same-cycle credit reuse.
- Simultaneous push and pop on a FIFO, including a full response FIFO when pop is true, is legal. Pointers wrap modulo NumOutstanding, with a separate full/empty bit.
- Reset mid-operation clears all state. In-flight memory responses after reset are the integrator's responsibility and are not tracked.

## Configuration
- SNITCH_LSU_MEM_ADAPTER_BYPASS_EN defined: when the response FIFO is empty and mem_rvalid_i=1, mem_rdata_i and mem_err_i drive the data_p* outputs in the same cycle with data_pvalid_o=1. If data_pready_i=1 the entry is not pushed; otherwise it is pushed.
- Undefined: responses always take one cycle through the FIFO.

## Test plan
- Single load: qid=2, addr=0x100, gnt same cycle, rvalid two cycles later with rdata=0xDEADBEEF -> pvalid one cycle later (same cycle with bypass), pid=2, pdata=0xDEADBEEF, cnt returns to 0.
- Credit exhaustion, NumOutstanding=4: 5 back-to-back requests with gnt=1 and no rvalid -> 4 grants, then mem_req_o=0 and data_qready_o=0. One LSU pop -> fifth request issued the next cycle.
- LSU stall: 4 grants with IDs 3,1,0,2; 4 rvalids with data_pready_i=0 -> all buffered. Raise pready -> 4 responses in order with pid 3,1,0,2, no data lost.
- Simultaneous: cnt=2 with a grant and a response handshake in the same cycle -> cnt stays 2, FIFO pointers wrap correctly over 3×NumOutstanding transactions.
- Error and write: write with qid=1 returns mem_err_i=1 -> pvalid with pid=1, perror=1.
- Reset asserted with 3 outstanding -> all outputs at reset values; a new request after reset is issued and answered normally.

Source files
------------

// File: rtl/snitch_lsu_mem_adapter.sv
// snitch_lsu_mem_adapter: bridges the Snitch LSU ID-tagged channel to a TCDM req/gnt port,
// replaying transaction IDs on responses and buffering responses across LSU stalls.
// Optional same-cycle response bypass: define SNITCH_LSU_MEM_ADAPTER_BYPASS_EN.
module snitch_lsu_mem_adapter #(
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned IdWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        data_qaddr_i,
  input  logic               data_qwrite_i,
  input  logic [3:0]         data_qamo_i,
  input  logic [31:0]        data_qdata_i,
  input  logic [3:0]         data_qstrb_i,
  input  logic [IdWidth-1:0] data_qid_i,
  input  logic               data_qvalid_i,
  output logic               data_qready_o,
  output logic [31:0]        data_pdata_o,
  output logic               data_perror_o,
  output logic [IdWidth-1:0] data_pid_o,
  output logic               data_pvalid_o,
  input  logic               data_pready_i,
  output logic               mem_req_o,
  input  logic               mem_gnt_i,
  output logic [31:0]        mem_addr_o,
  output logic               mem_we_o,
  output logic [3:0]         mem_amo_o,
  output logic [31:0]        mem_wdata_o,
  output logic [3:0]         mem_be_o,
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i,
  input  logic               mem_err_i
);
  localparam int unsigned CntW = $clog2(NumOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(NumOutstanding);
  localparam logic [IdWidth-1:0] LastPtr = IdWidth'(NumOutstanding - 1);

  logic [CntW-1:0]    cnt_q, cnt_d, rsp_cnt;
  logic               credit_ok, grant, hs, bypass;
  logic [IdWidth-1:0] id_q [NumOutstanding];
  logic [IdWidth-1:0] id_wptr_q, id_rptr_q;
  logic [32:0]        rsp_q [NumOutstanding];
  logic [IdWidth-1:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic               rsp_full_q, rsp_full_d, rsp_empty, rsp_push, rsp_pop;
  logic [32:0]        head;

  function automatic logic [IdWidth-1:0] inc(input logic [IdWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign credit_ok     = cnt_q < MaxCnt;
  assign mem_req_o     = data_qvalid_i & credit_ok;
  assign data_qready_o = mem_gnt_i & credit_ok;
  assign grant         = mem_req_o & mem_gnt_i;
  assign hs            = data_pvalid_o & data_pready_i;
  assign cnt_d         = cnt_q + CntW'(grant) - CntW'(hs);

  assign mem_addr_o  = data_qaddr_i;
  assign mem_we_o    = data_qwrite_i;
  assign mem_amo_o   = data_qamo_i;
  assign mem_wdata_o = data_qdata_i;
  assign mem_be_o    = data_qstrb_i;

  assign rsp_empty = (rsp_wptr_q == rsp_rptr_q) & ~rsp_full_q;
`ifdef SNITCH_LSU_MEM_ADAPTER_BYPASS_EN
  assign bypass = rsp_empty & mem_rvalid_i;
`else
  assign bypass = 1'b0;
`endif
  assign head          = bypass ? {mem_rdata_i, mem_err_i} : rsp_q[rsp_rptr_q];
  assign data_pvalid_o = ~rsp_empty | bypass;
  assign data_pdata_o  = head[32:1];
  assign data_perror_o = head[0];
  assign data_pid_o    = id_q[id_rptr_q];

  // A bypassed response that the LSU takes immediately never enters the FIFO.
  assign rsp_push   = mem_rvalid_i & ~(bypass & data_pready_i);
  assign rsp_pop    = ~rsp_empty & data_pready_i;
  assign rsp_wptr_d = rsp_push ? inc(rsp_wptr_q) : rsp_wptr_q;
  assign rsp_rptr_d = rsp_pop ? inc(rsp_rptr_q) : rsp_rptr_q;
  assign rsp_full_d = (rsp_push & ~rsp_pop) ? (rsp_wptr_d == rsp_rptr_q) :
                      (rsp_pop & ~rsp_push) ? 1'b0 : rsp_full_q;

  // Track how many responses sit in the FIFO, to detect unsolicited rvalid.
  assign rsp_cnt = rsp_full_q ? MaxCnt :
                   (rsp_wptr_q >= rsp_rptr_q) ? CntW'(rsp_wptr_q - rsp_rptr_q) :
                   MaxCnt - CntW'(rsp_rptr_q) + CntW'(rsp_wptr_q);

  // Credit counter: granted transactions not yet accepted by the LSU.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  // ID FIFO: capture the LSU ID on grant, release it on the response handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumOutstanding; i++) id_q[i] <= '0;
      id_wptr_q <= '0;
      id_rptr_q <= '0;
    end else begin
      if (grant) begin
        id_q[id_wptr_q] <= data_qid_i;
        id_wptr_q       <= inc(id_wptr_q);
      end
      if (hs) id_rptr_q <= inc(id_rptr_q);
    end
  end

  // Response FIFO: holds memory responses until the LSU is ready for them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumOutstanding; i++) rsp_q[i] <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
      rsp_full_q <= 1'b0;
    end else begin
      if (rsp_push) rsp_q[rsp_wptr_q] <= {mem_rdata_i, mem_err_i};
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
      rsp_full_q <= rsp_full_d;
    end
  end

  a_no_unsolicited_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (cnt_q > rsp_cnt));
endmodule

// File: tb/tb_snitch_lsu_mem_adapter.sv
// tb_snitch_lsu_mem_adapter: directed bench with a queue-based reference model.
module tb_snitch_lsu_mem_adapter;
`ifdef SNITCH_LSU_MEM_ADAPTER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int N = 4;

  logic        clk, rst_n;
  logic [31:0] qaddr, qdata, pdata, maddr, mwdata, rdata;
  logic [3:0]  qamo, qstrb, mamo, mbe;
  logic [1:0]  qid, pid;
  logic        qwrite, qvalid, qready, perror, pvalid, pready;
  logic        mreq, mgnt, mwe, rvalid, merr;

  int checks = 0;
  int errors = 0;

  int          cnt_m;
  logic [1:0]  idq[$];
  logic [32:0] rspq[$];
  logic        ok, e_req, e_rdy, e_pv;
  logic [32:0] head;

  snitch_lsu_mem_adapter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_qaddr_i(qaddr), .data_qwrite_i(qwrite), .data_qamo_i(qamo),
    .data_qdata_i(qdata), .data_qstrb_i(qstrb), .data_qid_i(qid),
    .data_qvalid_i(qvalid), .data_qready_o(qready),
    .data_pdata_o(pdata), .data_perror_o(perror), .data_pid_o(pid),
    .data_pvalid_o(pvalid), .data_pready_i(pready),
    .mem_req_o(mreq), .mem_gnt_i(mgnt), .mem_addr_o(maddr), .mem_we_o(mwe),
    .mem_amo_o(mamo), .mem_wdata_o(mwdata), .mem_be_o(mbe),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .mem_err_i(merr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: compare at negedge, then advance to the state after the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      idq.delete();
      rspq.delete();
      cnt_m = 0;
    end
    ok    = cnt_m < N;
    e_req = qvalid && ok;
    e_rdy = mgnt && ok;
    e_pv  = (rspq.size() > 0) || (BYP && rvalid);
    chk("mem_req", 32'(mreq), 32'(e_req));
    chk("qready", 32'(qready), 32'(e_rdy));
    chk("pvalid", 32'(pvalid), 32'(e_pv));
    chk("mem_addr", maddr, qaddr);
    chk("mem_we", 32'(mwe), 32'(qwrite));
    chk("mem_amo", 32'(mamo), 32'(qamo));
    chk("mem_wdata", mwdata, qdata);
    chk("mem_be", 32'(mbe), 32'(qstrb));
    if (!rst_n) begin
      chk("rst_pdata", pdata, 32'h0);
      chk("rst_perror", 32'(perror), 32'h0);
      chk("rst_pid", 32'(pid), 32'h0);
    end else if (e_pv) begin
      head = (rspq.size() > 0) ? rspq[0] : {rdata, merr};
      chk("pdata", pdata, head[32:1]);
      chk("perror", 32'(perror), 32'(head[0]));
      if (idq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pid_model: got %h, want none (no id outstanding)", pid);
      end else chk("pid", 32'(pid), 32'(idq[0]));
    end
    if (rst_n) begin
      if (e_req && mgnt) begin
        idq.push_back(qid);
        cnt_m++;
      end
      if (rvalid) rspq.push_back({rdata, merr});
      if (e_pv && pready) begin
        void'(rspq.pop_front());
        void'(idq.pop_front());
        cnt_m--;
      end
    end
  end

  initial begin
    int ids[4] = '{3, 1, 0, 2};
    rst_n = 0; qaddr = 0; qwrite = 0; qamo = 0; qdata = 0; qstrb = 0; qid = 0;
    qvalid = 0; pready = 0; mgnt = 0; rvalid = 0; rdata = 0; merr = 0;
    repeat (3) cyc();
    rst_n = 1;
    #1;
    chk("lit_rst_pvalid", 32'(pvalid), 32'h0);
    chk("lit_rst_req", 32'(mreq), 32'h0);

    // Single load
    cyc();
    qvalid = 1; qid = 2; qaddr = 32'h100; mgnt = 1;
    #1;
    chk("lit_load_req", 32'(mreq), 32'h1);
    chk("lit_load_qready", 32'(qready), 32'h1);
    chk("lit_load_addr", maddr, 32'h100);
    cyc();
    qvalid = 0; mgnt = 0;
    cyc();
    rvalid = 1; rdata = 32'hDEADBEEF; pready = 1;
    #1;
    if (BYP) chk("lit_load_bypass_data", pdata, 32'hDEADBEEF);
    cyc();
    rvalid = 0; rdata = 0;
    #1;
    if (!BYP) begin
      chk("lit_load_pvalid", 32'(pvalid), 32'h1);
      chk("lit_load_pdata", pdata, 32'hDEADBEEF);
      chk("lit_load_pid", 32'(pid), 32'h2);
    end
    cyc();
    #1;
    chk("lit_load_done", 32'(pvalid), 32'h0);
    chk("lit_load_cnt", 32'(cnt_m), 32'h0);

    // Credit exhaustion
    pready = 0; qvalid = 1; mgnt = 1;
    for (int i = 0; i < 4; i++) begin
      qid = 2'(i); qaddr = 32'h200 + 32'(4 * i);
      #1;
      chk("lit_cred_qready", 32'(qready), 32'h1);
      cyc();
    end
    qid = 0;
    #1;
    chk("lit_full_req", 32'(mreq), 32'h0);
    chk("lit_full_qready", 32'(qready), 32'h0);
    rvalid = 1; rdata = 32'hA0;
    cyc();
    rvalid = 0; pready = 1;
    #1;
    chk("lit_full_pid", 32'(pid), 32'h0);
    chk("lit_full_pdata", pdata, 32'hA0);
    chk("lit_full_noreuse", 32'(mreq), 32'h0);
    cyc();
    pready = 0;
    #1;
    chk("lit_fifth_req", 32'(mreq), 32'h1);
    chk("lit_fifth_qready", 32'(qready), 32'h1);
    cyc();
    qvalid = 0; mgnt = 0; pready = 1;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'hB0 + 32'(i);
      cyc();
    end
    rvalid = 0;
    repeat (3) cyc();
    chk("lit_cred_cnt", 32'(cnt_m), 32'h0);

    // LSU stall with out-of-order IDs
    pready = 0; qvalid = 1; mgnt = 1;
    for (int i = 0; i < 4; i++) begin
      qid = 2'(ids[i]);
      cyc();
    end
    qvalid = 0; mgnt = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'hC0 + 32'(i);
      cyc();
    end
    rvalid = 0; pready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lit_stall_pid", 32'(pid), 32'(ids[k]));
      chk("lit_stall_pdata", pdata, 32'hC0 + 32'(k));
      cyc();
    end
    #1;
    chk("lit_stall_empty", 32'(pvalid), 32'h0);

    // Simultaneous grant and handshake at cnt=2, wrapping pointers
    cyc();
    pready = 0; qvalid = 1; mgnt = 1; qid = 0;
    cyc();
    qid = 1; rvalid = 1; rdata = 32'hD000;
    cyc();
    for (int i = 0; i < 12; i++) begin
      qid = 2'(i + 2); rdata = 32'hD001 + 32'(i); pready = 1;
      #1;
      chk("lit_sim_qready", 32'(qready), 32'h1);
      cyc();
      chk("lit_sim_cnt", 32'(cnt_m), 32'h2);
    end
    qvalid = 0; mgnt = 0; rdata = 32'hD00D;
    cyc();
    rvalid = 0;
    repeat (3) cyc();
    chk("lit_sim_drain", 32'(cnt_m), 32'h0);

    // Write returning an error
    qvalid = 1; qwrite = 1; qid = 1; qdata = 32'h55; qstrb = 4'hF; qamo = 4'h2; mgnt = 1; pready = 0;
    #1;
    chk("lit_wr_we", 32'(mwe), 32'h1);
    cyc();
    qvalid = 0; qwrite = 0; mgnt = 0; qamo = 0;
    rvalid = 1; merr = 1; rdata = 0;
    cyc();
    rvalid = 0; merr = 0;
    #1;
    chk("lit_wr_pvalid", 32'(pvalid), 32'h1);
    chk("lit_wr_pid", 32'(pid), 32'h1);
    chk("lit_wr_perror", 32'(perror), 32'h1);
    pready = 1;
    cyc();
    #1;
    chk("lit_wr_done", 32'(pvalid), 32'h0);

    // Reset with three outstanding
    pready = 0; qvalid = 1; mgnt = 1;
    for (int i = 0; i < 3; i++) begin
      qid = 2'(i + 1);
      cyc();
    end
    qvalid = 0; mgnt = 0; rvalid = 1; rdata = 32'hE1; merr = 1;
    cyc();
    rvalid = 0; rdata = 0; merr = 0;
    rst_n = 0;
    #1;
    chk("lit_mrst_pvalid", 32'(pvalid), 32'h0);
    chk("lit_mrst_pdata", pdata, 32'h0);
    chk("lit_mrst_perror", 32'(perror), 32'h0);
    chk("lit_mrst_pid", 32'(pid), 32'h0);
    chk("lit_mrst_qready", 32'(qready), 32'h0);
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    qvalid = 1; qid = 3; qaddr = 32'h200; mgnt = 1;
    #1;
    chk("lit_post_req", 32'(mreq), 32'h1);
    cyc();
    qvalid = 0; mgnt = 0;
    cyc();
    rvalid = 1; rdata = 32'h12345678; pready = 1;
    cyc();
    rvalid = 0;
    repeat (2) cyc();
    chk("lit_post_cnt", 32'(cnt_m), 32'h0);
    chk("lit_post_pvalid", 32'(pvalid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
